fifo_uart_tx: RTL

// - Downstream drain stage for the 8-bit FWFT fifo; serialises each stored byte onto a UART line, 8N1, LSB first.
// - Watches the fifo empty flag and pops one byte per frame with a single-cycle read_request pulse.
// - Tolerates the fifo's registered data output: empty falls one cycle before the new head byte is valid.

---
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/fifo_uart_tx.sv | 119 +++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the FWFT fifo read side, the UART drain stage and its observers.
// The slave modport is the drain stage; the master modport is whatever drives the fifo side.
interface fifo_uart_tx_if;
  logic        enable;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        tx;
  logic        busy;
  logic [15:0] frames_sent;

  modport master (
    output enable, fifo_data, fifo_empty,
    input  fifo_rd, tx, busy, frames_sent
  );

  modport slave (
    input  enable, fifo_data, fifo_empty,
    output fifo_rd, tx, busy, frames_sent
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit FWFT fifo onto an 8N1 UART line, LSB first, one pop per frame.
// state  | meaning
// IDLE   | line high; wait for enable with fifo non-empty
// SETTLE | one cycle for the fifo's registered head byte to catch up; pop on exit
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | eight data bits, shift[0] on the line
// STOP   | stop bit (high); count the frame on exit
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT)
) (
  input logic           clk,
  input logic           reset,
  fifo_uart_tx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETTLE, START, DATA, STOP} state_e;

  localparam logic [CNT_W-1:0] TIMER_TC = CNT_W'(CLKS_PER_BIT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               rd_q, rd_d;
  logic [15:0]        frames_q, frames_d;
  logic               tc;

  assign tc = (timer_q == TIMER_TC);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rd_d      = 1'b0;
    frames_d  = frames_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (bus.enable && !bus.fifo_empty) state_d = SETTLE;
      end
      SETTLE: begin
        timer_d = '0;
        if (bus.fifo_empty) begin
          state_d = IDLE;
        end else begin
          state_d = START;
          shift_d = bus.fifo_data;
          rd_d    = 1'b1;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tc) begin
          state_d   = DATA;
          timer_d   = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (tc) begin
          timer_d   = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          // shift_q[1] is the bit that lands in shift[0] on this edge
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tc) begin
          state_d  = IDLE;
          timer_d  = '0;
          frames_d = frames_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      rd_q      <= 1'b0;
      frames_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      frames_q  <= frames_d;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.fifo_rd     = rd_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frames_sent = frames_q;

endmodule
